// File: rtl/lvds_pkg.sv
// lvds_pkg: state encoding and default timing for the LVDS capture controller.
package lvds_pkg;
    typedef enum logic [2:0] {PWR_OFF, REL_A, REL_D, IDLE, CAPTURE, GAP, DONE, ERROR} state_t;
    localparam int DEF_T_RSTA    = 1000;
    localparam int DEF_T_RSTD    = 1000;
    localparam int DEF_T_SETTLE  = 10000;
    localparam int DEF_T_GAP     = 64;
    localparam int DEF_T_TIMEOUT = 65535;
    localparam int DEF_CNT_W     = 16;
endpackage

// File: rtl/lvds_capture_ctrl_if.sv
// lvds_capture_ctrl_if: run control, sensor reset and status signals of the capture controller.
interface lvds_capture_ctrl_if #(parameter int CNT_W = 16);
    logic             start, stop, err_clr, mode_cont, burst_done, fifo_overflow;
    logic [CNT_W-1:0] frame_total, frame_cnt;
    logic             rst_a, rst_d, cap_en, ready, busy, err_ovf, err_tmo, irq;
    modport slave (
        input  start, stop, err_clr, mode_cont, frame_total, burst_done, fifo_overflow,
        output rst_a, rst_d, cap_en, ready, busy, frame_cnt, err_ovf, err_tmo, irq
    );
    modport master (
        output start, stop, err_clr, mode_cont, frame_total, burst_done, fifo_overflow,
        input  rst_a, rst_d, cap_en, ready, busy, frame_cnt, err_ovf, err_tmo, irq
    );
endinterface

// File: rtl/lvds_ctrl_timer.sv
// lvds_ctrl_timer: loadable down-counter that holds at zero and flags it.
module lvds_ctrl_timer #(
    parameter int W = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= RST_VAL;
        else cnt <= load ? load_val : (cnt != '0 ? cnt - W'(1) : cnt);
    assign zero = cnt == '0;
endmodule

// File: rtl/lvds_capture_ctrl.sv
// lvds_capture_ctrl: sensor power-up sequencing and burst capture run control.
module lvds_capture_ctrl
    import lvds_pkg::*;
#(
    parameter int T_RSTA    = DEF_T_RSTA,
    parameter int T_RSTD    = DEF_T_RSTD,
    parameter int T_SETTLE  = DEF_T_SETTLE,
    parameter int T_GAP     = DEF_T_GAP,
    parameter int T_TIMEOUT = DEF_T_TIMEOUT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input logic clk,
    input logic rst_n,
    lvds_capture_ctrl_if.slave bus
);
    // A state lasting t cycles loads t-1, so the transition fires on the t-th cycle.
    function automatic logic [CNT_W-1:0] ld(input int t);
        return t > 0 ? CNT_W'(t - 1) : '0;
    endfunction
    function automatic logic [CNT_W-1:0] dur(input state_t s);
        return s == PWR_OFF ? ld(T_RSTA) : s == REL_A ? ld(T_RSTD) : s == REL_D ? ld(T_SETTLE) :
               s == CAPTURE ? ld(T_TIMEOUT) : s == GAP ? ld(T_GAP) : '0;
    endfunction
    state_t           state, nxt;
    logic [CNT_W-1:0] cnt_inc, total_q;
    logic             cont_q, stop_q, stop_seen, last, tmr_zero;
    assign cnt_inc   = bus.frame_cnt + CNT_W'(1);
    assign stop_seen = stop_q | bus.stop;
    assign last      = !cont_q && cnt_inc == total_q;
    lvds_ctrl_timer #(.W(CNT_W), .RST_VAL(ld(T_RSTA))) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (nxt != state),
        .load_val (dur(nxt)),
        .zero     (tmr_zero)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= PWR_OFF;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            PWR_OFF: nxt = tmr_zero ? REL_A : state;
            REL_A:   nxt = tmr_zero ? REL_D : state;
            REL_D:   nxt = tmr_zero ? IDLE : state;
            IDLE:    nxt = bus.start ? CAPTURE : state;
            CAPTURE: nxt = bus.fifo_overflow ? ERROR : bus.burst_done ? (last || stop_seen ? DONE : GAP) :
                           tmr_zero ? ERROR : state;
            GAP:     nxt = bus.fifo_overflow ? ERROR : tmr_zero ? (stop_seen ? DONE : CAPTURE) : state;
            DONE:    nxt = IDLE;
            ERROR:   nxt = bus.err_clr ? IDLE : state;
            default: nxt = PWR_OFF;
        endcase
    end
    // Outputs are registered from the next state so they change together with state.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.frame_cnt <= '0;
            total_q       <= CNT_W'(1);
            cont_q        <= 1'b0;
            stop_q        <= 1'b0;
            bus.err_ovf   <= 1'b0;
            bus.err_tmo   <= 1'b0;
            bus.rst_a     <= 1'b0;
            bus.rst_d     <= 1'b0;
            bus.ready     <= 1'b0;
            bus.cap_en    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.irq       <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                bus.frame_cnt <= '0;
                cont_q        <= bus.mode_cont;
                total_q       <= bus.frame_total == '0 ? CNT_W'(1) : bus.frame_total;
            end else if (state == CAPTURE && bus.burst_done && !bus.fifo_overflow)
                bus.frame_cnt <= cnt_inc;
            stop_q      <= nxt == IDLE ? 1'b0 : (state inside {CAPTURE, GAP} && bus.stop) ? 1'b1 : stop_q;
            bus.err_ovf <= nxt == IDLE ? 1'b0 : (state inside {CAPTURE, GAP} && bus.fifo_overflow) ? 1'b1 : bus.err_ovf;
            bus.err_tmo <= nxt == IDLE ? 1'b0 : (state == CAPTURE && nxt == ERROR && !bus.fifo_overflow) ? 1'b1 : bus.err_tmo;
            bus.rst_a   <= nxt != PWR_OFF;
            bus.rst_d   <= !(nxt inside {PWR_OFF, REL_A});
            bus.ready   <= !(nxt inside {PWR_OFF, REL_A, REL_D});
            bus.cap_en  <= nxt == CAPTURE;
            bus.busy    <= nxt inside {CAPTURE, GAP, DONE};
            bus.irq     <= nxt == DONE || (nxt == ERROR && state != ERROR);
        end
endmodule

// File: tb/tb_lvds_capture_ctrl.sv
// tb_lvds_capture_ctrl: directed and random checks of the capture controller against a behavioural model.
module tb_lvds_capture_ctrl;
    localparam int TMO  = 40;
    localparam int GAPN = 4;
    logic clk = 0;
    logic rst_n = 0;
    int   n_tests = 0, n_fail = 0, irq_seen = 0;
    bit   chk_en = 0;
    lvds_capture_ctrl_if #(.CNT_W(16)) bus();
    lvds_capture_ctrl #(
        .T_RSTA(10), .T_RSTD(10), .T_SETTLE(10), .T_GAP(GAPN), .T_TIMEOUT(TMO), .CNT_W(16)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Model: cycles since reset release, plus run bookkeeping in plain counters.
    int          up = 0, gap_left = 0, age = 0;
    bit          running = 0, in_gap = 0, finishing = 0, stop_req = 0;
    bit          m_ovf = 0, m_tmo = 0, m_irq = 0, m_cont = 0;
    logic [15:0] m_cnt = 0, m_tot = 1;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            up = 0; running = 0; in_gap = 0; finishing = 0; stop_req = 0;
            m_ovf = 0; m_tmo = 0; m_irq = 0; m_cnt = 0;
        end else begin
            m_irq = 0;
            if (up < 30) up++;
            else if (m_ovf || m_tmo) begin
                if (bus.err_clr) begin m_ovf = 0; m_tmo = 0; end
            end else if (finishing) begin
                finishing = 0; running = 0; stop_req = 0;
            end else if (!running) begin
                if (bus.start) begin
                    running = 1; in_gap = 0; age = 0; m_cnt = 0; stop_req = 0;
                    m_cont = bus.mode_cont;
                    m_tot = bus.frame_total == 0 ? 16'd1 : bus.frame_total;
                end
            end else begin
                if (bus.stop) stop_req = 1;
                if (bus.fifo_overflow) begin
                    m_ovf = 1; m_irq = 1; running = 0;
                end else if (!in_gap) begin
                    age++;
                    if (bus.burst_done) begin
                        m_cnt = m_cnt + 16'd1;
                        if ((!m_cont && m_cnt == m_tot) || stop_req) begin finishing = 1; m_irq = 1; end
                        else begin in_gap = 1; gap_left = GAPN; end
                    end else if (age == TMO) begin
                        m_tmo = 1; m_irq = 1; running = 0;
                    end
                end else begin
                    gap_left--;
                    if (gap_left == 0) begin
                        if (stop_req) begin finishing = 1; m_irq = 1; end
                        else begin in_gap = 0; age = 0; end
                    end
                end
            end
        end
    end
    function automatic logic [23:0] exp_vec();
        return {up >= 10, up >= 20, running && !in_gap && !finishing, up >= 30, running, m_irq, m_ovf, m_tmo, m_cnt};
    endfunction
    function automatic logic [23:0] act_vec();
        return {bus.rst_a, bus.rst_d, bus.cap_en, bus.ready, bus.busy, bus.irq, bus.err_ovf, bus.err_tmo, bus.frame_cnt};
    endfunction
    function automatic bit m_idle();
        return up >= 30 && !running && !m_ovf && !m_tmo;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (chk_en) check("cycle_outputs", act_vec(), exp_vec());
    always @(negedge clk) if (bus.irq) irq_seen++;
    task automatic power_up();
        rst_n = 1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 9 || i == 10) check("rst_a_rise", bus.rst_a, i == 10);
            if (i == 19 || i == 20) check("rst_d_rise", bus.rst_d, i == 20);
            if (i == 29 || i == 30) check("ready_rise", bus.ready, i == 30);
        end
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 200 && !m_idle(); i++) begin
            bus.err_clr = m_ovf || m_tmo;
            @(negedge clk);
        end
        bus.err_clr = 0;
        check("reach_idle", {bus.ready, bus.busy, bus.err_ovf, bus.err_tmo}, 4'b1000);
    endtask
    task automatic pulse_start(input bit cont, input logic [15:0] tot);
        bus.mode_cont = cont; bus.frame_total = tot; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
    endtask
    task automatic pulse_burst();
        bus.burst_done = 1;
        @(negedge clk);
        bus.burst_done = 0;
    endtask
    task automatic clear_inputs();
        bus.start = 0; bus.stop = 0; bus.err_clr = 0; bus.mode_cont = 0;
        bus.burst_done = 0; bus.fifo_overflow = 0; bus.frame_total = '0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int g, base;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk_en = 1;
        power_up();
        // Single-shot, three bursts with two measured gaps.
        wait_idle();
        base = irq_seen;
        pulse_start(0, 3);
        for (int b = 0; b < 3; b++) begin
            repeat (3) @(negedge clk);
            pulse_burst();
            if (b < 2) begin
                g = 0;
                while (!bus.cap_en && g < 20) begin g++; @(negedge clk); end
                check("gap_width", g, GAPN);
            end
        end
        @(negedge clk);
        check("ss_frame_cnt", bus.frame_cnt, 3);
        check("ss_irq_count", irq_seen - base, 1);
        // Continuous run, stop during a burst.
        wait_idle();
        pulse_start(1, 0);
        repeat (2) @(negedge clk);
        bus.stop = 1;
        @(negedge clk);
        bus.stop = 0;
        for (int i = 0; i < 3; i++) begin
            check("stop_cap_hold", bus.cap_en, 1);
            @(negedge clk);
        end
        pulse_burst();
        check("stop_done", {bus.busy, bus.cap_en, bus.irq}, 3'b101);
        @(negedge clk);
        check("stop_idle", {bus.busy, bus.ready, bus.frame_cnt}, {2'b01, 16'd1});
        // Burst and overflow together: overflow wins, burst not counted.
        wait_idle();
        pulse_start(0, 5);
        repeat (2) @(negedge clk);
        bus.burst_done = 1; bus.fifo_overflow = 1;
        @(negedge clk);
        bus.burst_done = 0; bus.fifo_overflow = 0;
        check("sim_cnt", bus.frame_cnt, 0);
        check("sim_ovf_irq", {bus.err_ovf, bus.irq, bus.cap_en}, 3'b110);
        repeat (2) @(negedge clk);
        bus.err_clr = 1;
        @(negedge clk);
        bus.err_clr = 0;
        check("clr_flags", {bus.err_ovf, bus.err_tmo, bus.ready, bus.busy}, 4'b0010);
        // Timeout boundary.
        wait_idle();
        pulse_start(0, 2);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_before", {bus.err_tmo, bus.cap_en}, 2'b01);
        @(negedge clk);
        check("tmo_after", {bus.err_tmo, bus.err_ovf, bus.cap_en, bus.busy, bus.irq}, 5'b10001);
        // Random traffic.
        wait_idle();
        for (int i = 0; i < 3000; i++) begin
            bus.start         = $urandom_range(0, 7) == 0;
            bus.stop          = $urandom_range(0, 19) == 0;
            bus.burst_done    = $urandom_range(0, 5) == 0;
            bus.fifo_overflow = $urandom_range(0, 149) == 0;
            bus.err_clr       = $urandom_range(0, 9) == 0;
            bus.mode_cont     = $urandom_range(0, 1) == 1;
            bus.frame_total   = 16'($urandom_range(0, 4));
            @(negedge clk);
        end
        clear_inputs();
        wait_idle();
        // Reset in the middle of a capture.
        pulse_start(1, 0);
        repeat (3) @(negedge clk);
        check("pre_rst_cap", bus.cap_en, 1);
        #2 rst_n = 0;
        #1 check("rst_immediate", {bus.cap_en, bus.rst_a, bus.rst_d, bus.ready, bus.busy}, 5'b00000);
        repeat (2) @(negedge clk);
        power_up();
        wait_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lvds_capture_ctrl.md
LVDS_CAPTURE_CTRL -- requirements
Module: lvds_capture_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- T_RSTA, 1000: clk cycles sensor held in full reset before RST_A release.
- T_RSTD, 1000: clk cycles between RST_A release and RST_D release.
- T_SETTLE, 10000: clk cycles after RST_D release before ready.
- T_GAP, 64: idle cycles between consecutive bursts.
- T_TIMEOUT, 65535: maximum CAPTURE cycles without burst_done.
- CNT_W, 16: timer width, frame_total width and frame_cnt width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: module clock, 100 MHz.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse; begins a capture run.
- stop, in, 1: one-cycle pulse; ends the run at the next burst boundary.
- err_clr, in, 1: one-cycle pulse; clears error flags, leaves ERROR.
- mode_cont, in, 1: 1 = continuous, 0 = single-shot; sampled at start.
- frame_total, in, CNT_W: bursts per single-shot run; sampled at start; 0 is treated as 1.
- burst_done, in, 1: one-cycle pulse, already synchronous to clk; one burst is committed to the FIFO.
- fifo_overflow, in, 1: level, synchronous to clk.
- rst_a, out, 1: sensor XSHUTDOWN, active-low.
- rst_d, out, 1: sensor RSTN, active-low.
- cap_en, out, 1: write-enable gate to the receive datapath.
- ready, out, 1: sensor initialised.
- busy, out, 1: a run is in progress.
- frame_cnt, out, CNT_W: bursts completed in the current or last run.
- err_ovf, out, 1: sticky overflow error.
- err_tmo, out, 1: sticky timeout error.
- irq, out, 1: one-cycle pulse at the end of a run or on entry to an error.

Function
REQ-003 The FSM SHALL have these states: PWR_OFF, REL_A, REL_D, IDLE, CAPTURE, GAP, DONE, ERROR. One down-counter timer is reloaded on every state entry.
REQ-004 PWR_OFF SHALL drive rst_a=0 and rst_d=0, and SHALL go to REL_A after T_RSTA cycles.
REQ-005 REL_A SHALL drive rst_a=1 and rst_d=0, and SHALL go to REL_D after T_RSTD cycles.
REQ-006 REL_D SHALL drive rst_a=1 and rst_d=1, and SHALL go to IDLE after T_SETTLE cycles.
REQ-007 ready SHALL be 1 in IDLE, CAPTURE, GAP, DONE and ERROR, and 0 otherwise.
REQ-008 start SHALL be acted on only in IDLE; a start in IDLE SHALL clear frame_cnt, latch mode_cont and frame_total, and enter CAPTURE on the next cycle. A start in any other state SHALL be ignored.
REQ-009 cap_en SHALL be 1 only in CAPTURE, registered, asserting on the first cycle of CAPTURE.
REQ-010 In CAPTURE, burst_done SHALL increment frame_cnt (wrapping modulo 2^CNT_W) and enter GAP, except when the last single-shot burst is reached (new frame_cnt == latched frame_total), in which case the FSM SHALL enter DONE.
REQ-011 GAP SHALL wait T_GAP cycles and then return to CAPTURE, unless a stop pulse has been recorded, in which case it SHALL enter DONE.
REQ-012 A stop pulse in CAPTURE or GAP SHALL be recorded in a flag; the current burst SHALL never be truncated. stop in any other state SHALL be ignored. The flag SHALL be cleared on entry to IDLE.
REQ-013 If burst_done and stop arrive in the same cycle, the FSM SHALL count the burst and then enter DONE.
REQ-014 DONE SHALL pulse irq for exactly one cycle and then enter IDLE.
REQ-015 fifo_overflow=1 in CAPTURE or GAP SHALL set err_ovf and enter ERROR; this SHALL take priority over a burst_done in the same cycle, which is then not counted.
REQ-016 If the CAPTURE timer expires, the block SHALL set err_tmo and enter ERROR.
REQ-017 On entry to ERROR the block SHALL pulse irq once. While in ERROR, cap_en=0; err_clr SHALL clear both flags and enter IDLE.
REQ-018 busy SHALL be 1 in CAPTURE, GAP and DONE.
REQ-019 frame_cnt SHALL hold its value in IDLE and ERROR.

Reset
REQ-020 While rst_n=0, the block SHALL force: state=PWR_OFF, rst_a=0, rst_d=0, cap_en=0, ready=0, busy=0, irq=0, frame_cnt=0, err_ovf=0, err_tmo=0.
REQ-021 A reset asserted mid-run SHALL drop cap_en immediately and restart the full power-up sequence.

Structure
REQ-022 A shared package lvds_pkg SHALL hold the state encoding and the default timing constants.
REQ-023 One sub-module, lvds_ctrl_timer (loadable down-counter with a zero flag), SHALL be instantiated once.

Verification
REQ-024 The bench SHALL cover these directed scenarios (using T_RSTA=T_RSTD=T_SETTLE=10 and T_GAP=4):
- Power-up: release reset -> rst_a rises at cycle 10, rst_d at cycle 20, ready at cycle 30.
- Single-shot: frame_total=3, mode_cont=0, start, 3 burst_done -> frame_cnt=3, one irq pulse, cap_en low for exactly 4 cycles in each of the 2 gaps.
- Continuous run, stop mid-burst: stop issued during a burst -> cap_en stays 1 until burst_done, then DONE, then IDLE.
- Simultaneous events: burst_done and fifo_overflow in the same cycle -> frame_cnt not incremented, err_ovf=1, irq pulse; err_clr -> IDLE with both flags 0.
- Timeout: no burst_done for T_TIMEOUT cycles -> err_tmo=1, cap_en=0.
- Reset mid-CAPTURE: assert rst_n=0 -> cap_en=0 and rst_a=0 immediately, and the sequence restarts.
